galaga_rom_loader: RTL and testbench
====================================

GALAGA_ROM_LOADER -- requirements
Module: galaga_rom_loader

Interface
REQ-001 Parameter ROM_INDEX, default 8'h00: ioctl_index value that selects the core ROM image.
REQ-002 Parameter ROM_SIZE, default 17'h10000: expected image length in bytes.
REQ-003 Parameter SETTLE_CYCLES, default 1024: hold-off cycles after download ends before core reset releases.
REQ-004 clk_sys  in  1  single system clock; all logic rises on it.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_download  in  1  data_io download-active level.
REQ-007 ioctl_index  in  8  data_io image index.
REQ-008 ioctl_wr  in  1  one-cycle byte strobe from data_io.
REQ-009 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-010 ioctl_dout  in  8  download byte.
REQ-011 dn_addr  out  16  registered ROM write address to core.
REQ-012 dn_data  out  8  registered ROM write data to core.
REQ-013 dn_wr  out  1  one-cycle ROM write strobe to core.
REQ-014 core_reset  out  1  reset request to core (ORed with user reset at top level).
REQ-015 rom_ok  out  1  image loaded complete and in order.
REQ-016 rom_err  out  1  last download short, long or out of sequence.
REQ-017 byte_cnt  out  17  bytes accepted in current/last download.
REQ-018 chk_sum  out  8  modulo-256 sum of accepted bytes.

Function
REQ-019 States: IDLE, LOAD, SETTLE, DONE; encoding free.
REQ-020 IDLE -> LOAD when ioctl_download=1 and ioctl_index=ROM_INDEX; clears byte_cnt, chk_sum, rom_ok, rom_err, sets seq_err/ovf internal flags to 0.
REQ-021 Downloads with ioctl_index!=ROM_INDEX are ignored: no dn_wr, no state change, counters untouched.
REQ-022 In LOAD, each ioctl_wr with ioctl_addr<ROM_SIZE produces dn_wr=1 exactly one cycle later with dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout (latency 1).
REQ-023 Accepted write increments byte_cnt by 1 and adds ioctl_dout to chk_sum, wrapping mod 256.
REQ-024 Write with ioctl_addr>=ROM_SIZE: no dn_wr, byte_cnt unchanged, sets ovf flag.
REQ-025 Accepted write with ioctl_addr!=byte_cnt (pre-increment value): still forwarded, sets seq_err flag.
REQ-026 byte_cnt saturates at ROM_SIZE; never wraps.
REQ-027 LOAD -> SETTLE on first cycle ioctl_download=0; an ioctl_wr arriving in that same cycle is still processed per REQ-022..026.
REQ-028 SETTLE counts SETTLE_CYCLES clocks, then -> DONE; rom_ok/rom_err update on SETTLE entry.
REQ-029 rom_err=1 when ovf or seq_err or byte_cnt!=ROM_SIZE; rom_ok=~rom_err.
REQ-030 core_reset=1 in IDLE (before first download), LOAD and SETTLE; 0 in DONE only if rom_ok=1, else stays 1.
REQ-031 DONE -> LOAD on new matching download (REQ-020), re-asserting core_reset the same cycle the state changes.
REQ-032 SETTLE interrupted by a new matching download -> LOAD immediately; settle counter discarded.
REQ-033 dn_wr never asserted outside LOAD and the single trailing cycle after it; never two cycles in a row without two ioctl_wr strobes.
REQ-034 Parameter SETTLE_CYCLES=0 -> SETTLE lasts exactly one cycle.

Reset
REQ-035 On reset=1 at a clk_sys edge: state IDLE, dn_wr=0, dn_addr=0, dn_data=0, core_reset=1, rom_ok=0, rom_err=0, byte_cnt=0, chk_sum=0, settle counter 0.
REQ-036 Reset mid-LOAD abandons the download; a still-high ioctl_download with matching index re-enters LOAD on the first cycle after reset deasserts.

Verification
REQ-037 Index 0, 65536 sequential bytes value addr[7:0] -> 65536 dn_wr pulses, byte_cnt=0x10000, chk_sum=0x00, rom_ok=1, core_reset falls 1024 cycles after ioctl_download falls.
REQ-038 Index 1 download of 100 bytes -> no dn_wr, state remains IDLE/DONE, byte_cnt unchanged.
REQ-039 Index 0, only 0x8000 bytes -> rom_err=1, rom_ok=0, core_reset stays 1 after SETTLE.
REQ-040 Write at addr 0x10000 inside a full image -> dropped, no dn_wr, rom_err=1.
REQ-041 Bytes at addr 0,1,3,2 (ROM_SIZE=4) -> four dn_wr forwarded, rom_err=1 (sequence).
REQ-042 reset pulse after 10 bytes while ioctl_download high -> outputs per REQ-035, then LOAD restarts with byte_cnt=0 and counts subsequent bytes only.

Source files
------------

// File: rtl/galaga_rom_loader_if.sv
// rtl/galaga_rom_loader_if.sv - data_io download bus and core ROM write bus
interface galaga_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    // master: data_io side (drives the download, observes ROM writes)
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    // slave: the loader itself
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/galaga_rom_loader.sv
// rtl/galaga_rom_loader.sv - forwards the Galaga ROM image to the core and gates core reset
module galaga_rom_loader #(
    parameter logic [7:0]  ROM_INDEX     = 8'h00,
    parameter logic [16:0] ROM_SIZE      = 17'h10000,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic                clk_sys,
    input  logic                reset,
    galaga_rom_loader_if.slave  io,
    output logic                core_reset,
    output logic                rom_ok,
    output logic                rom_err,
    output logic [16:0]         byte_cnt,
    output logic [7:0]          chk_sum
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_DONE} state_t;

    // A zero settle length still spends one cycle in SETTLE.
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam int          CW          = $clog2(SETTLE_LAST + 2);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_LAST);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_settle_cnt;
    logic            r_ovf;
    logic            r_seq_err;
    logic            r_rom_ok;
    logic            r_rom_err;
    logic            r_dn_wr;
    logic [15:0]     r_dn_addr;
    logic [7:0]      r_dn_data;
    logic [16:0]     r_byte_cnt;
    logic [7:0]      r_chk_sum;

    logic            w_match;
    logic            w_start;
    logic            w_in_load;
    logic            w_in_range;
    logic            w_accept;
    logic            w_drop;
    logic            w_seq_bad;
    logic            w_load_end;
    logic [16:0]     w_cnt_nxt;
    logic            w_ovf_nxt;
    logic            w_seq_nxt;
    logic            w_err_nxt;

    assign w_match    = io.ioctl_download && (io.ioctl_index == ROM_INDEX);
    assign w_start    = w_match && (r_state != S_LOAD);
    assign w_in_load  = (r_state == S_LOAD);
    assign w_in_range = (io.ioctl_addr < {8'd0, ROM_SIZE});
    assign w_accept   = w_in_load && io.ioctl_wr && w_in_range;
    assign w_drop     = w_in_load && io.ioctl_wr && !w_in_range;
    assign w_seq_bad  = w_accept && (io.ioctl_addr != {8'd0, r_byte_cnt});
    assign w_load_end = w_in_load && !io.ioctl_download;
    assign w_cnt_nxt  = (w_accept && (r_byte_cnt != ROM_SIZE)) ? r_byte_cnt + 17'd1 : r_byte_cnt;
    assign w_ovf_nxt  = r_ovf | w_drop;
    assign w_seq_nxt  = r_seq_err | w_seq_bad;
    // Verdict includes a write landing in the same cycle the download drops.
    assign w_err_nxt  = w_ovf_nxt | w_seq_nxt | (w_cnt_nxt != ROM_SIZE);

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: a matching download pre-empts SETTLE and DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_match) w_state_nxt = S_LOAD;
            S_LOAD:   if (!io.ioctl_download) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (w_match)                         w_state_nxt = S_LOAD;
                else if (r_settle_cnt == SETTLE_END) w_state_nxt = S_DONE;
            end
            S_DONE:   if (w_match) w_state_nxt = S_LOAD;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: core held in reset unless a good image has fully settled
    always_comb begin
        core_reset = !((r_state == S_DONE) && r_rom_ok);
        rom_ok     = r_rom_ok;
        rom_err    = r_rom_err;
        byte_cnt   = r_byte_cnt;
        chk_sum    = r_chk_sum;
        io.dn_wr   = r_dn_wr;
        io.dn_addr = r_dn_addr;
        io.dn_data = r_dn_data;
    end

    // Settle counter runs only while in SETTLE; restarts from zero on each entry
    always_ff @(posedge clk_sys) begin
        if (reset || (r_state != S_SETTLE) || w_match) r_settle_cnt <= '0;
        else if (r_settle_cnt != SETTLE_END)           r_settle_cnt <= r_settle_cnt + CW'(1);
    end

    // Write forwarding, counters, error flags and the verdict latched on LOAD exit
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dn_wr    <= 1'b0;
            r_dn_addr  <= 16'd0;
            r_dn_data  <= 8'd0;
            r_byte_cnt <= 17'd0;
            r_chk_sum  <= 8'd0;
            r_ovf      <= 1'b0;
            r_seq_err  <= 1'b0;
            r_rom_ok   <= 1'b0;
            r_rom_err  <= 1'b0;
        end else begin
            r_dn_wr <= w_accept;
            if (w_accept) begin
                r_dn_addr <= io.ioctl_addr[15:0];
                r_dn_data <= io.ioctl_dout;
            end
            if (w_start) begin
                r_byte_cnt <= 17'd0;
                r_chk_sum  <= 8'd0;
                r_ovf      <= 1'b0;
                r_seq_err  <= 1'b0;
                r_rom_ok   <= 1'b0;
                r_rom_err  <= 1'b0;
            end else if (w_in_load) begin
                r_byte_cnt <= w_cnt_nxt;
                r_chk_sum  <= r_chk_sum + (w_accept ? io.ioctl_dout : 8'd0);
                r_ovf      <= w_ovf_nxt;
                r_seq_err  <= w_seq_nxt;
                if (w_load_end) begin
                    r_rom_err <= w_err_nxt;
                    r_rom_ok  <= !w_err_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_galaga_rom_loader.sv
// tb/tb_galaga_rom_loader.sv - scoreboard bench for galaga_rom_loader
module tb_galaga_rom_loader;
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        cr_a, ok_a, err_a, cr_b, ok_b, err_b;
    logic [16:0] cnt_a, cnt_b;
    logic [7:0]  sum_a, sum_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int         size_m[2]   = '{65536, 4};
    int         settle_m[2] = '{1024, 0};
    int         m_cnt[2];
    int         m_sum[2];
    bit         m_bad[2];
    bit         m_active[2];
    bit         m_done_ok[2];
    logic [7:0] idx_cur[2];

    galaga_rom_loader_if ifa ();
    galaga_rom_loader_if ifb ();

    galaga_rom_loader #(.ROM_INDEX(8'h00), .ROM_SIZE(17'h10000), .SETTLE_CYCLES(1024)) dut_a (
        .clk_sys(clk), .reset(rst_a), .io(ifa),
        .core_reset(cr_a), .rom_ok(ok_a), .rom_err(err_a), .byte_cnt(cnt_a), .chk_sum(sum_a)
    );

    galaga_rom_loader #(.ROM_INDEX(8'h00), .ROM_SIZE(17'd4), .SETTLE_CYCLES(0)) dut_b (
        .clk_sys(clk), .reset(rst_b), .io(ifb),
        .core_reset(cr_b), .rom_ok(ok_b), .rom_err(err_b), .byte_cnt(cnt_b), .chk_sum(sum_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: every ROM write must match the oldest expected write, one cycle after issue
    always @(negedge clk) begin
        if (ifa.dn_wr === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_dn_wr actual=write@%0h required=no_write", ifa.dn_addr);
            end else begin
                ea = qa.pop_front();
                chk("a_dn_addr", ifa.dn_addr, ea.addr);
                chk("a_dn_data", ifa.dn_data, ea.data);
                chk("a_dn_latency", cyc, ea.stamp + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.dn_wr === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_dn_wr actual=write@%0h required=no_write", ifb.dn_addr);
            end else begin
                eb = qb.pop_front();
                chk("b_dn_addr", ifb.dn_addr, eb.addr);
                chk("b_dn_data", ifb.dn_data, eb.data);
                chk("b_dn_latency", cyc, eb.stamp + 1);
            end
        end
    end

    function automatic logic get_cr(int d);   return (d == 0) ? cr_a  : cr_b;  endfunction
    function automatic logic get_ok(int d);   return (d == 0) ? ok_a  : ok_b;  endfunction
    function automatic logic get_err(int d);  return (d == 0) ? err_a : err_b; endfunction
    function automatic logic [16:0] get_cnt(int d); return (d == 0) ? cnt_a : cnt_b; endfunction
    function automatic logic [7:0]  get_sum(int d); return (d == 0) ? sum_a : sum_b; endfunction
    function automatic int get_qsize(int d);  return (d == 0) ? qa.size() : qb.size(); endfunction
    function automatic string pfx(int d);     return (d == 0) ? "a_" : "b_"; endfunction

    task automatic set_in(int d, logic dl, logic [7:0] idx, logic wr, logic [24:0] addr, logic [7:0] dout);
        if (d == 0) begin
            ifa.ioctl_download = dl; ifa.ioctl_index = idx; ifa.ioctl_wr = wr;
            ifa.ioctl_addr = addr; ifa.ioctl_dout = dout;
        end else begin
            ifb.ioctl_download = dl; ifb.ioctl_index = idx; ifb.ioctl_wr = wr;
            ifb.ioctl_addr = addr; ifb.ioctl_dout = dout;
        end
    endtask

    task automatic model_clear(int d);
        m_cnt[d] = 0;
        m_sum[d] = 0;
        m_bad[d] = 1'b0;
    endtask

    // Reference: in-range bytes are forwarded; count saturates at the image size
    task automatic model_write(int d, logic [24:0] addr, logic [7:0] data);
        exp_t e;
        if (!m_active[d]) return;
        if (int'(addr) < size_m[d]) begin
            e.addr = addr[15:0]; e.data = data; e.stamp = cyc;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
            if (int'(addr) != m_cnt[d]) m_bad[d] = 1'b1;
            if (m_cnt[d] < size_m[d]) m_cnt[d] = m_cnt[d] + 1;
            m_sum[d] = (m_sum[d] + int'(data)) % 256;
        end else begin
            m_bad[d] = 1'b1;
        end
    endtask

    task automatic begin_dl(int d, logic [7:0] idx);
        @(negedge clk);
        idx_cur[d] = idx;
        set_in(d, 1'b1, idx, 1'b0, 25'd0, 8'd0);
        m_active[d] = (idx == 8'h00);
        if (m_active[d]) model_clear(d);
        @(negedge clk);
        if (m_active[d]) begin
            chk({pfx(d), "load_core_reset"}, get_cr(d), 1);
            chk({pfx(d), "load_cnt_clear"}, get_cnt(d), 0);
            chk({pfx(d), "load_sum_clear"}, get_sum(d), 0);
            chk({pfx(d), "load_ok_clear"}, get_ok(d), 0);
        end
    endtask

    task automatic put_byte(int d, logic [24:0] addr, logic [7:0] data);
        @(negedge clk);
        set_in(d, 1'b1, idx_cur[d], 1'b1, addr, data);
        model_write(d, addr, data);
    endtask

    task automatic idle(int d, int n);
        repeat (n) begin
            @(negedge clk);
            set_in(d, 1'b1, idx_cur[d], 1'b0, 25'd0, 8'd0);
        end
    endtask

    // Drop download (optionally with a final byte in the same cycle) and judge the outcome
    task automatic end_dl(int d, bit with_byte, logic [24:0] addr, logic [7:0] data);
        int  k0, fall, bound;
        bit  ok;
        @(negedge clk);
        set_in(d, 1'b0, idx_cur[d], with_byte, addr, data);
        if (with_byte) model_write(d, addr, data);
        k0    = cyc;
        fall  = -1;
        bound = 1 + ((settle_m[d] > 1) ? settle_m[d] : 1);
        for (int i = 0; i < bound + 3; i++) begin
            @(negedge clk);
            set_in(d, 1'b0, idx_cur[d], 1'b0, 25'd0, 8'd0);
            if (get_cr(d) == 1'b0 && fall < 0) fall = cyc;
        end
        if (m_active[d]) begin
            ok = !m_bad[d] && (m_cnt[d] == size_m[d]);
            if (ok) chk({pfx(d), "core_reset_fall_delay"}, fall - k0, bound);
            else    chk({pfx(d), "core_reset_held_cycle"}, fall, -1);
            chk({pfx(d), "rom_ok"}, get_ok(d), ok);
            chk({pfx(d), "rom_err"}, get_err(d), !ok);
            chk({pfx(d), "byte_cnt"}, get_cnt(d), m_cnt[d]);
            chk({pfx(d), "chk_sum"}, get_sum(d), m_sum[d]);
            m_done_ok[d] = ok;
        end else begin
            chk({pfx(d), "ignored_byte_cnt"}, get_cnt(d), m_cnt[d]);
            chk({pfx(d), "ignored_core_reset"}, get_cr(d), !m_done_ok[d]);
        end
        chk({pfx(d), "writes_drained"}, get_qsize(d), 0);
    endtask

    task automatic check_reset_state(int d);
        chk({pfx(d), "rst_core_reset"}, get_cr(d), 1);
        chk({pfx(d), "rst_rom_ok"}, get_ok(d), 0);
        chk({pfx(d), "rst_rom_err"}, get_err(d), 0);
        chk({pfx(d), "rst_byte_cnt"}, get_cnt(d), 0);
        chk({pfx(d), "rst_chk_sum"}, get_sum(d), 0);
        chk({pfx(d), "rst_dn_wr"}, (d == 0) ? ifa.dn_wr : ifb.dn_wr, 0);
        chk({pfx(d), "rst_dn_addr"}, (d == 0) ? ifa.dn_addr : ifb.dn_addr, 0);
        chk({pfx(d), "rst_dn_data"}, (d == 0) ? ifa.dn_data : ifb.dn_data, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          len, tail;
        logic [24:0] a;
        rst_a = 1'b1; rst_b = 1'b1;
        idx_cur[0] = 8'h00; idx_cur[1] = 8'h00;
        for (int d = 0; d < 2; d++) begin
            model_clear(d); m_active[d] = 1'b0; m_done_ok[d] = 1'b0;
        end
        set_in(0, 1'b0, 8'h00, 1'b0, 25'd0, 8'd0);
        set_in(1, 1'b0, 8'h00, 1'b0, 25'd0, 8'd0);
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_a = 1'b0; rst_b = 1'b0;

        // Foreign image index before any load: ignored, core stays in reset
        begin_dl(0, 8'h01);
        for (int i = 0; i < 100; i++) put_byte(0, 25'(i), 8'($urandom));
        end_dl(0, 1'b0, 25'd0, 8'd0);

        // Full sequential image with byte value = low address byte
        begin_dl(0, 8'h00);
        for (int i = 0; i < 65536; i++) put_byte(0, 25'(i), 8'(i));
        end_dl(0, 1'b0, 25'd0, 8'd0);
        chk("a_full_cnt_const", cnt_a, 17'h10000);
        chk("a_full_sum_const", sum_a, 8'h00);

        // Foreign image index after a good load: core keeps running
        begin_dl(0, 8'h01);
        for (int i = 0; i < 100; i++) put_byte(0, 25'(i), 8'($urandom));
        end_dl(0, 1'b0, 25'd0, 8'd0);

        // Reset in the middle of a load, download level still high
        begin_dl(0, 8'h00);
        for (int i = 0; i < 10; i++) put_byte(0, 25'(i), 8'($urandom_range(1, 255)));
        idle(0, 1);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check_reset_state(0);
        chk("a_rst_writes_drained", qa.size(), 0);
        rst_a = 1'b0;
        model_clear(0);
        m_done_ok[0] = 1'b0;
        @(negedge clk);
        chk("a_rst_reload_cnt", cnt_a, 0);
        chk("a_rst_reload_core_reset", cr_a, 1);
        for (int i = 0; i < 20; i++) put_byte(0, 25'(i), 8'($urandom));
        end_dl(0, 1'b0, 25'd0, 8'd0);

        // Short image with random gaps, last byte coincident with download drop
        begin_dl(0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            put_byte(0, 25'(i), 8'($urandom));
            idle(0, $urandom_range(0, 2));
        end
        end_dl(0, 1'b1, 25'd300, 8'($urandom));

        // Small image: out-of-order bytes 0,1,3,2
        begin_dl(1, 8'h00);
        put_byte(1, 25'd0, 8'h11); put_byte(1, 25'd1, 8'h22);
        put_byte(1, 25'd3, 8'h44); put_byte(1, 25'd2, 8'h33);
        end_dl(1, 1'b0, 25'd0, 8'd0);

        // Small image: complete, then one byte past the end
        begin_dl(1, 8'h00);
        for (int i = 0; i < 5; i++) put_byte(1, 25'(i), 8'($urandom));
        end_dl(1, 1'b0, 25'd0, 8'd0);

        // Small image: clean load, one-cycle settle
        begin_dl(1, 8'h00);
        for (int i = 0; i < 4; i++) put_byte(1, 25'(i), 8'($urandom));
        end_dl(1, 1'b0, 25'd0, 8'd0);

        // Settle interrupted by a new matching download
        begin_dl(1, 8'h00);
        put_byte(1, 25'd0, 8'h5a); put_byte(1, 25'd1, 8'ha5);
        @(negedge clk);
        set_in(1, 1'b0, 8'h00, 1'b0, 25'd0, 8'd0);
        @(negedge clk);
        set_in(1, 1'b1, 8'h00, 1'b0, 25'd0, 8'd0);
        model_clear(1);
        @(negedge clk);
        chk("b_interrupt_core_reset", cr_b, 1);
        chk("b_interrupt_cnt_clear", cnt_b, 0);
        for (int i = 0; i < 4; i++) put_byte(1, 25'(i), 8'($urandom));
        end_dl(1, 1'b0, 25'd0, 8'd0);

        // Randomised small-image downloads
        for (int n = 0; n < 40; n++) begin
            begin_dl(1, ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00);
            len  = $urandom_range(0, 7);
            tail = (len > 0) ? $urandom_range(0, 1) : 0;
            for (int i = 0; i < len - tail; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 6)) : 25'(i);
                put_byte(1, a, 8'($urandom));
                idle(1, $urandom_range(0, 2));
            end
            a = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 6)) : 25'(len - 1);
            end_dl(1, tail[0], a, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
